bht_predictor: RTL
==================

Name: bht_predictor

Overview:
- Parametrised branch history table: 2^IDX_W saturating counters, each CTR_W bits wide.
- Indexed by branch PC, optionally XORed with a global history register (gshare mode).
- Provides a registered prediction port and a training port. Sits between fetch (predict) and branch resolution (train).
- Generalises the single 2-bit counter to multiple entries, configurable width, saturation, and history indexing.

Parameters:
- IDX_W, 6, index width; table holds 2^IDX_W entries.
- CTR_W, 2, counter width in bits; must be >= 2.
- PC_W, 32, PC input width; must be >= IDX_W.
- HIST_W, 0, global history length; 0 = pure bimodal; must be <= IDX_W.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- resetn  input  1  synchronous active-low reset.
- predict_valid  input  1  prediction request this cycle.
- predict_pc  input  PC_W  PC of branch to predict.
- predict_out_valid  output  1  prediction result valid (one cycle after request).
- predict_taken  output  1  MSB of looked-up counter.
- predict_count  output  CTR_W  full looked-up counter value.
- predict_hist  output  max(HIST_W,1)  GHR snapshot used for the lookup; caller returns it at train time.
- train_valid  input  1  training update this cycle.
- train_pc  input  PC_W  PC of resolved branch.
- train_hist  input  max(HIST_W,1)  history snapshot captured at predict time.
- train_taken  input  1  resolved direction.

Behaviour:
- Weak-NT value: WNT = 2^(CTR_W-1)-1. For CTR_W=2 this is 2'b01.
- Reset (resetn=0 at a rising edge):
  - All counters <= WNT.
  - GHR <= 0.
  - predict_out_valid, predict_taken, predict_count, predict_hist <= 0.
  - Any predict or train in the same cycle is ignored.
  - Applies equally mid-operation.
- Index function:
  - idx = pc[IDX_W-1:0] XOR zero-extended history.
  - When HIST_W=0, idx = pc[IDX_W-1:0]; the hist ports are tied/ignored (predict_hist driven 0).
- Predict, 1-cycle latency:
  - predict_valid=1 at edge t registers table[idx(predict_pc, GHR)] into predict_count.
  - Its MSB goes to predict_taken; the GHR value goes to predict_hist.
  - predict_out_valid=1 for exactly the following cycle.
  - predict_valid=0 gives predict_out_valid=0; the data outputs hold their previous values.
  - Back-to-back requests are accepted every cycle.
- Train:
  - train_valid=1 at edge t updates table[idx(train_pc, train_hist)].
  - If train_taken: counter+1, saturating at 2^CTR_W-1.
  - Else: counter-1, saturating at 0.
  - No wrap-around in either direction.
  - If HIST_W>0: GHR <= {GHR[HIST_W-2:0], train_taken}. With HIST_W=1, GHR <= train_taken.
- Simultaneous predict and train, same index, same edge:
  - Prediction returns the pre-update counter value (no forwarding) unless BHT_BYPASS_EN is defined.
  - Lookup uses the GHR value before that edge's shift.
- Different indices: fully independent; both complete in the same cycle.
- Arithmetic is CTR_W bits with explicit saturation checks; no carry is retained.
- Storage is flops, so a full-table reset completes in one cycle. No stall or ready signal: the block is always ready.

Optional Feature:
- Macro: BHT_BYPASS_EN.
- Defined: when a predict and a train hit the same index at the same edge, predict_count/predict_taken return the post-update saturated value.
- Defined: with HIST_W>0, the predict lookup still uses the pre-shift GHR. Only the counter value is forwarded.
- Undefined: the pre-update value is returned (read-before-write).
- No other behaviour differs.

Test Plan:
- Reset value:
  - Stimulus: resetn=0 for 2 cycles, release; predict pc=0x00, then pc=0x3F.
  - Required response: predict_count=2'b01, predict_taken=0, predict_out_valid high one cycle after each request.
- Saturation up/down (HIST_W=0):
  - Stimulus: train pc=0x04 taken x4, predict pc=0x04.
  - Required response: count=2'b11. Then train not-taken x5 → count=2'b00, with no wrap to 11.
- Aliasing and independence:
  - Stimulus: train pc=0x05 taken x2, then predict pc=0x45 (IDX_W=6, aliases to 0x05) and pc=0x06.
  - Required response: 0x45 → 2'b11; 0x06 → 2'b01.
- Same-index collision:
  - Setup: pc=0x10 holds count 2'b01.
  - Stimulus: predict and train(taken) pc=0x10 on the same edge.
  - Required response: 2'b01 without BHT_BYPASS_EN; 2'b10 with it. A following predict returns 2'b10 in both builds.
- Gshare (HIST_W=4, CTR_W=3):
  - Stimulus: train T,T,NT,T (GHR=4'b1101), then predict pc=0x02.
  - Required response: lookup index 0x0F, predict_hist=4'b1101, count=3'b011 (WNT).
  - Follow-up: train pc=0x02 with train_hist=4'b1101 taken, then predict pc=0x0F with GHR=4'b1011 (index 0x04, WNT) as a control.
- Mid-operation reset:
  - Setup: several counters trained to saturation.
  - Stimulus: resetn=0 for one cycle while predict_valid=1 and train_valid=1.
  - Required response: predict_out_valid=0 the next cycle; all entries read WNT and GHR=0 afterwards.

Source files
------------

// File: rtl/bht_predictor.sv
// Branch history table: 2^IDX_W saturating counters, bimodal or gshare indexed,
// with a registered predict port and a train port. Optional macro: BHT_BYPASS_EN.

module bht_ctr_entry #(
    parameter int              CTR_W = 2,
    parameter logic [CTR_W-1:0] WNT  = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [CTR_W-1:0] wr_val,
    output logic [CTR_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!resetn)
            count <= WNT;
        else if (wr_en)
            count <= wr_val;
    end
endmodule

module bht_predictor #(
    parameter int IDX_W  = 6,
    parameter int CTR_W  = 2,
    parameter int PC_W   = 32,
    parameter int HIST_W = 0
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 predict_valid,
    input  logic [PC_W-1:0]                      predict_pc,
    output logic                                 predict_out_valid,
    output logic                                 predict_taken,
    output logic [CTR_W-1:0]                     predict_count,
    output logic [(HIST_W > 0 ? HIST_W : 1)-1:0] predict_hist,
    input  logic                                 train_valid,
    input  logic [PC_W-1:0]                      train_pc,
    input  logic [(HIST_W > 0 ? HIST_W : 1)-1:0] train_hist,
    input  logic                                 train_taken
);
    localparam int               HW      = (HIST_W > 0) ? HIST_W : 1;
    localparam int               ENTRIES = 1 << IDX_W;
    localparam int               STAGES  = 1;
    localparam logic [CTR_W-1:0] WNT     = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MIN = '0;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic [HW-1:0]    hist;
    } pred_req_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic             taken;
    } train_req_t;

    logic [ENTRIES-1:0][CTR_W-1:0] ctr_q;
    logic [HW-1:0]                 ghr_q;
    logic [IDX_W-1:0]              ghr_ext;
    logic [IDX_W-1:0]              thist_ext;
    pred_req_t                     preq;
    train_req_t                    treq;
    logic [CTR_W-1:0]              t_rd;
    logic [CTR_W-1:0]              t_wr;
    logic [CTR_W-1:0]              p_rd;
    logic [STAGES:1]               vld_pipe;
    logic                          unused_bits;

    // Upper PC bits never reach the index; bimodal builds ignore train_hist.
    assign unused_bits = ^{predict_pc, train_pc, train_hist};

    generate
        if (HIST_W > 0) begin : g_hist
            assign ghr_ext   = IDX_W'(ghr_q);
            assign thist_ext = IDX_W'(train_hist);
            always_ff @(posedge clk) begin
                if (!resetn)
                    ghr_q <= '0;
                else if (train_valid)
                    ghr_q <= (HIST_W == 1) ? HW'(train_taken)
                                           : HW'({ghr_q, train_taken});
            end
        end else begin : g_nohist
            assign ghr_ext   = '0;
            assign thist_ext = '0;
            assign ghr_q     = '0;
        end
    endgenerate

    always_comb begin
        preq       = '0;
        preq.vld   = predict_valid;
        preq.idx   = predict_pc[IDX_W-1:0] ^ ghr_ext;
        preq.hist  = ghr_q;
        treq       = '0;
        treq.vld   = train_valid;
        treq.idx   = train_pc[IDX_W-1:0] ^ thist_ext;
        treq.taken = train_taken;
    end

    // Single shared saturating update; only the addressed entry latches it.
    always_comb begin
        t_rd = ctr_q[treq.idx];
        t_wr = t_rd;
        if (treq.taken) begin
            if (t_rd != CTR_MAX)
                t_wr = t_rd + 1'b1;
        end else begin
            if (t_rd != CTR_MIN)
                t_wr = t_rd - 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
            bht_ctr_entry #(
                .CTR_W (CTR_W),
                .WNT   (WNT)
            ) u_ent (
                .clk    (clk),
                .resetn (resetn),
                .wr_en  (treq.vld && (treq.idx == IDX_W'(i))),
                .wr_val (t_wr),
                .count  (ctr_q[i])
            );
        end
    endgenerate

    always_comb begin
        p_rd = ctr_q[preq.idx];
`ifdef BHT_BYPASS_EN
        // Forward the counter only; the lookup index still uses the pre-shift GHR.
        if (treq.vld && (treq.idx == preq.idx))
            p_rd = t_wr;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_pipe      <= '0;
            predict_count <= '0;
            predict_hist  <= '0;
        end else begin
            vld_pipe[1] <= preq.vld;
            for (int s = 2; s <= STAGES; s++)
                vld_pipe[s] <= vld_pipe[s-1];
            if (preq.vld) begin
                predict_count <= p_rd;
                predict_hist  <= preq.hist;
            end
        end
    end

    assign predict_out_valid = vld_pipe[STAGES];
    assign predict_taken     = predict_count[CTR_W-1];

endmodule
